// File: rtl/sdp_ram_pkg.sv
// Shared defaults and types for the simple-dual-port RAM responder.
// The SDP_RAM_WRITE_BYPASS_EN build option is consumed by sdp_ram_responder.
package sdp_ram_pkg;

  localparam int DEF_ADDR_WIDTH  = 10;
  localparam int DEF_DATA_WIDTH  = 18;
  localparam int OUT_DEPTH_FIXED = 2;

  // Counts 0..2 outstanding responses.
  typedef logic [1:0] out_cnt_t;

  function automatic out_cnt_t cnt_step(input out_cnt_t cnt, input logic inc, input logic dec);
    out_cnt_t nxt;
    nxt = cnt;
    if (inc && !dec) begin
      nxt = cnt + 2'd1;
    end else if (dec && !inc) begin
      nxt = cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/sdp_ram_responder_if.sv
// Write port plus read request/response handshake of the SDP RAM responder.
// The slave modport is the memory side; the master modport is the requester.
interface sdp_ram_responder_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 18
);

  logic                  wce;
  logic [ADDR_WIDTH-1:0] wa;
  logic [DATA_WIDTH-1:0] wd;
  logic                  rce;
  logic [ADDR_WIDTH-1:0] ra;
  logic                  rce_ready;
  logic [DATA_WIDTH-1:0] rq;
  logic                  rq_valid;
  logic                  rq_ready;

  modport slave (
    input  wce, wa, wd, rce, ra, rq_ready,
    output rce_ready, rq, rq_valid
  );

  modport master (
    output wce, wa, wd, rce, ra, rq_ready,
    input  rce_ready, rq, rq_valid
  );

endinterface

// File: rtl/sdp_ram_skid_buf.sv
// Two-entry ordered response buffer with fall-through: an incoming word goes
// straight to the output when the buffer is empty, otherwise it queues behind.
module sdp_ram_skid_buf
  import sdp_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  input  logic                  out_ready_i
);

  logic [DATA_WIDTH-1:0] buf_q [2];
  logic                  head_q, head_d;
  logic                  tail_q, tail_d;
  out_cnt_t              count_q, count_d;
  logic                  empty;
  logic                  push;
  logic                  pop;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    head_d  = head_q;
    tail_d  = tail_q;
    empty   = (count_q == 2'd0);
    // The upstream outstanding count guarantees a free slot whenever in_valid_i is high.
    push    = in_valid_i && !(empty && out_ready_i);
    pop     = !empty && out_ready_i;
    if (push) tail_d = ~tail_q;
    if (pop)  head_d = ~head_q;
    count_d = cnt_step(count_q, push, pop);
  end

  // NOTE: storage is not reset; only the pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (push) buf_q[tail_q] <= in_data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign out_valid_o = !empty || in_valid_i;
  assign out_data_o  = empty ? in_data_i : buf_q[head_q];

endmodule

// File: rtl/sdp_ram_responder.sv
// Simple-dual-port RAM with registered one-cycle read and a ready/valid response path.
// Define SDP_RAM_WRITE_BYPASS_EN for write-first forwarding on same-address collisions.
module sdp_ram_responder
  import sdp_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int OUT_DEPTH  = OUT_DEPTH_FIXED
) (
  input  logic clk,
  input  logic rst_n,
  sdp_ram_responder_if.slave bus
);

  localparam int       DEPTH   = 2 ** ADDR_WIDTH;
  localparam out_cnt_t CNT_MAX = out_cnt_t'(OUT_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_d, rd_q;
  logic                  rd_valid_q;
  out_cnt_t              cnt_q, cnt_d;
  logic                  rce_ready;
  logic                  accept;
  logic                  consume;
  logic                  buf_valid;
  logic                  rq_valid;
  logic [DATA_WIDTH-1:0] buf_data;

  // Ready depends only on the count, never on the consumer's rq_ready.
  assign rce_ready = rst_n && (cnt_q < CNT_MAX);
  assign accept    = bus.rce && rce_ready;
  assign consume   = rq_valid && bus.rq_ready;

  always_ff @(posedge clk) begin
    if (bus.wce) mem_q[bus.wa] <= bus.wd;
  end

  always_comb begin
`ifdef SDP_RAM_WRITE_BYPASS_EN
    rd_d = (bus.wce && (bus.wa == bus.ra)) ? bus.wd : mem_q[bus.ra];
`else
    rd_d = mem_q[bus.ra];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q       <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= accept;
      if (accept) rd_q <= rd_d;
    end
  end

  always_comb begin
    cnt_d = cnt_step(cnt_q, accept, consume);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  sdp_ram_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (rd_valid_q),
    .in_data_i  (rd_q),
    .out_valid_o(buf_valid),
    .out_data_o (buf_data),
    .out_ready_i(bus.rq_ready)
  );

  // Responses are hidden while reset is held so nothing is consumed mid-reset.
  assign rq_valid      = rst_n && buf_valid;
  assign bus.rq_valid  = rq_valid;
  assign bus.rq        = buf_data;
  assign bus.rce_ready = rce_ready;

endmodule

// File: tb/tb_sdp_ram_responder.sv
// Directed self-checking bench for sdp_ram_responder; honours SDP_RAM_WRITE_BYPASS_EN.
module tb_sdp_ram_responder;

  localparam int AW = 10;
  localparam int DW = 18;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;
  logic [DW-1:0] model [1024];

  sdp_ram_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sdp_ram_responder #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .OUT_DEPTH (2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] fill_val(input int a);
    logic [31:0] v;
    v = a | (a << 20) | 32'h55000;
    return v[DW-1:0];
  endfunction

  // Advance one posedge and return on the following negedge for sampling/driving.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    total_cnt++;
    if (bus.rq_valid !== 1'b0) $display("FAIL reset_rq_valid: got %b want 0", bus.rq_valid);
    else pass_cnt++;
    total_cnt++;
    if (bus.rq !== 18'h0) $display("FAIL reset_rq: got %h want 0", bus.rq);
    else pass_cnt++;
    total_cnt++;
    if (bus.rce_ready !== 1'b0) $display("FAIL reset_rce_ready: got %b want 0", bus.rce_ready);
    else pass_cnt++;
    rst_n = 1'b1;
    #1;
    total_cnt++;
    if (bus.rce_ready !== 1'b1) $display("FAIL post_reset_ready: got %b want 1", bus.rce_ready);
    else pass_cnt++;
  endtask

  task automatic test_fill_readback();
    for (int a = 0; a < 1024; a++) begin
      bus.wce = 1'b1;
      bus.wa  = AW'(a);
      bus.wd  = fill_val(a);
      model[a] = fill_val(a);
      tick();
    end
    bus.wce      = 1'b0;
    bus.rq_ready = 1'b1;
    bus.rce      = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      bus.ra = AW'(i);
      tick();
      total_cnt++;
      if (bus.rq_valid !== 1'b1 || bus.rq !== model[i])
        $display("FAIL readback[%0d]: got valid=%b data=%h want valid=1 data=%h", i, bus.rq_valid, bus.rq, model[i]);
      else pass_cnt++;
      if (i == 3) begin
        total_cnt++;
        if (bus.rq !== 18'h15003) $display("FAIL readback_addr3: got %h want 15003", bus.rq);
        else pass_cnt++;
      end
      if (i == 1023) begin
        total_cnt++;
        if (bus.rq !== 18'h153FF) $display("FAIL readback_addr3ff: got %h want 153ff", bus.rq);
        else pass_cnt++;
      end
    end
    bus.rce = 1'b0;
    tick();
    total_cnt++;
    if (bus.rq_valid !== 1'b0 || bus.rq !== 18'h153FF)
      $display("FAIL idle_after_stream: got valid=%b data=%h want valid=0 data=153ff", bus.rq_valid, bus.rq);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] got [$];
    logic acc;
    got.delete();
    bus.rq_ready = 1'b0;
    bus.rce      = 1'b1;
    bus.ra       = 10'd1;
    tick();
    bus.ra = 10'd2;
    tick();
    bus.ra = 10'd3;
    for (int c = 0; c < 3; c++) begin
      // A write lands even while reads are blocked.
      bus.wce = (c == 0);
      bus.wa  = 10'd9;
      bus.wd  = 18'h0ABCD;
      total_cnt++;
      if (bus.rce_ready !== 1'b0) $display("FAIL bp_ready_drop[%0d]: got %b want 0", c, bus.rce_ready);
      else pass_cnt++;
      total_cnt++;
      if (bus.rq_valid !== 1'b1 || bus.rq !== 18'h15001)
        $display("FAIL bp_hold[%0d]: got valid=%b data=%h want valid=1 data=15001", c, bus.rq_valid, bus.rq);
      else pass_cnt++;
      tick();
    end
    bus.wce  = 1'b0;
    model[9] = 18'h0ABCD;
    bus.rq_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && got.size() < 4; cyc++) begin
      if (bus.rq_valid === 1'b1) got.push_back(bus.rq);
      acc = bus.rce && bus.rce_ready;
      tick();
      if (acc) begin
        if (bus.ra == 10'd4) bus.rce = 1'b0;
        else bus.ra = bus.ra + 10'd1;
      end
    end
    bus.rce = 1'b0;
    total_cnt++;
    if (got.size() != 4) $display("FAIL bp_count: got %0d responses want 4", got.size());
    else pass_cnt++;
    for (int i = 0; i < got.size(); i++) begin
      total_cnt++;
      if (got[i] !== 18'h15001 + 18'(i)) $display("FAIL bp_order[%0d]: got %h want %h", i, got[i], 18'h15001 + 18'(i));
      else pass_cnt++;
    end
    tick();
  endtask

  task automatic test_collision();
    logic [DW-1:0] exp_first;
`ifdef SDP_RAM_WRITE_BYPASS_EN
    exp_first = 18'h2AAAA;
`else
    exp_first = 18'h15005;
`endif
    bus.rq_ready = 1'b1;
    bus.wce = 1'b1;
    bus.wa  = 10'd5;
    bus.wd  = 18'h2AAAA;
    bus.rce = 1'b1;
    bus.ra  = 10'd5;
    tick();
    bus.wce  = 1'b0;
    bus.rce  = 1'b0;
    model[5] = 18'h2AAAA;
    total_cnt++;
    if (bus.rq_valid !== 1'b1 || bus.rq !== exp_first)
      $display("FAIL collision_read: got valid=%b data=%h want valid=1 data=%h", bus.rq_valid, bus.rq, exp_first);
    else pass_cnt++;
    tick();
    bus.rce = 1'b1;
    tick();
    bus.rce = 1'b0;
    total_cnt++;
    if (bus.rq_valid !== 1'b1 || bus.rq !== 18'h2AAAA)
      $display("FAIL collision_reread: got valid=%b data=%h want valid=1 data=2aaaa", bus.rq_valid, bus.rq);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid();
    bus.rq_ready = 1'b0;
    bus.rce = 1'b1;
    bus.ra  = 10'd1;
    tick();
    bus.ra = 10'd2;
    tick();
    bus.rce = 1'b0;
    total_cnt++;
    if (bus.rq_valid !== 1'b1) $display("FAIL rm_buffered: got %b want 1", bus.rq_valid);
    else pass_cnt++;
    rst_n = 1'b0;
    tick();
    total_cnt++;
    if (bus.rq_valid !== 1'b0 || bus.rce_ready !== 1'b0)
      $display("FAIL rm_during_reset: got valid=%b ready=%b want 0/0", bus.rq_valid, bus.rce_ready);
    else pass_cnt++;
    rst_n = 1'b1;
    tick();
    total_cnt++;
    if (bus.rq_valid !== 1'b0 || bus.rce_ready !== 1'b1 || bus.rq !== 18'h0)
      $display("FAIL rm_after_reset: got valid=%b ready=%b data=%h want 0/1/0", bus.rq_valid, bus.rce_ready, bus.rq);
    else pass_cnt++;
    bus.rq_ready = 1'b1;
    bus.rce = 1'b1;
    bus.ra  = 10'd7;
    tick();
    bus.rce = 1'b0;
    total_cnt++;
    if (bus.rq_valid !== 1'b1 || bus.rq !== 18'h15007)
      $display("FAIL rm_ram_kept: got valid=%b data=%h want valid=1 data=15007", bus.rq_valid, bus.rq);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_full_consume();
    bus.rq_ready = 1'b0;
    bus.rce = 1'b1;
    bus.ra  = 10'd10;
    tick();
    bus.ra = 10'd11;
    tick();
    bus.ra = 10'd12;
    bus.rq_ready = 1'b1;
    #1;
    total_cnt++;
    if (bus.rce_ready !== 1'b0) $display("FAIL full_no_comb_ready: got %b want 0", bus.rce_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.rce_ready !== 1'b1 || bus.rq !== model[11])
      $display("FAIL full_after_consume: got ready=%b data=%h want 1/%h", bus.rce_ready, bus.rq, model[11]);
    else pass_cnt++;
    tick();
    bus.rce = 1'b0;
    total_cnt++;
    if (bus.rce_ready !== 1'b1 || bus.rq_valid !== 1'b1 || bus.rq !== model[12])
      $display("FAIL acc_cons_same_edge: got ready=%b valid=%b data=%h want 1/1/%h", bus.rce_ready, bus.rq_valid, bus.rq, model[12]);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.rq_valid !== 1'b0) $display("FAIL full_drain: got %b want 0", bus.rq_valid);
    else pass_cnt++;
  endtask

  task automatic test_random_order();
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] exp_d;
    logic acc, cons;
    exp_q.delete();
    bus.rce = 1'b1;
    bus.ra  = AW'($urandom_range(0, 1023));
    for (int cyc = 0; cyc < 110; cyc++) begin
      bus.rq_ready = (cyc >= 100) ? 1'b1 : 1'($urandom_range(0, 1));
      if (cyc == 100) bus.rce = 1'b0;
      #1;
      total_cnt++;
      if (bus.rce_ready !== (exp_q.size() < 2))
        $display("FAIL rnd_ready[%0d]: got %b want %b", cyc, bus.rce_ready, exp_q.size() < 2);
      else pass_cnt++;
      acc  = bus.rce && bus.rce_ready;
      cons = bus.rq_valid && bus.rq_ready;
      if (cons) begin
        exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        total_cnt++;
        if (bus.rq !== exp_d) $display("FAIL rnd_order[%0d]: got %h want %h", cyc, bus.rq, exp_d);
        else pass_cnt++;
      end
      if (acc) exp_q.push_back(model[bus.ra]);
      tick();
      if (acc) bus.ra = AW'($urandom_range(0, 1023));
    end
    total_cnt++;
    if (exp_q.size() != 0 || bus.rq_valid !== 1'b0)
      $display("FAIL rnd_drain: got %0d pending valid=%b want 0 pending valid=0", exp_q.size(), bus.rq_valid);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt     = 0;
    total_cnt    = 0;
    rst_n        = 1'b0;
    bus.wce      = 1'b0;
    bus.wa       = '0;
    bus.wd       = '0;
    bus.rce      = 1'b0;
    bus.ra       = '0;
    bus.rq_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_fill_readback();
    test_backpressure();
    test_collision();
    test_reset_mid();
    test_full_consume();
    test_random_order();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
